// File: rtl/spi_tx_scheduler_pkg.sv
// rtl/spi_tx_scheduler_pkg.sv - shared types and header layout for the SPI TX scheduler (TRAILER state under SPI_TX_SCHED_CHECKSUM_EN)
package spi_tx_sched_pkg;

    localparam int   ID_W         = 2;
    localparam int   WORD_W       = 9;
    localparam logic HDR_MARKER   = 1'b1;

    // Header word layout: [8] marker, [7:6] source id, [5:0] payload length
    localparam int   HDR_MARK_BIT = 8;
    localparam int   HDR_ID_MSB   = 7;
    localparam int   HDR_ID_LSB   = 6;
    localparam int   HDR_LEN_MSB  = 5;
    localparam int   HDR_LEN_LSB  = 0;
    localparam int   HDR_LEN_W    = HDR_LEN_MSB - HDR_LEN_LSB + 1;

`ifdef SPI_TX_SCHED_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, TRAILER} state_t;
`else
    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;
`endif

    // Build a header word; the marker bit is what the receiver resyncs on
    function automatic logic [WORD_W-1:0] make_header(input logic [ID_W-1:0] id,
                                                      input logic [HDR_LEN_W-1:0] len);
        logic [WORD_W-1:0] w;
        w = '0;
        w[HDR_MARK_BIT]             = HDR_MARKER;
        w[HDR_ID_MSB:HDR_ID_LSB]    = id;
        w[HDR_LEN_MSB:HDR_LEN_LSB]  = len;
        return w;
    endfunction

endpackage

// File: rtl/spi_tx_scheduler_if.sv
// rtl/spi_tx_scheduler_if.sv - source-side and FIFO-side signal bundle of the SPI TX scheduler
interface spi_tx_scheduler_if #(
    parameter int N_SRC = 4,
    parameter int LEN_W = 6
);
    logic [N_SRC-1:0]       src_req;
    logic [N_SRC*LEN_W-1:0] src_len;
    logic [N_SRC*8-1:0]     src_data;
    logic [N_SRC-1:0]       src_valid;
    logic [N_SRC-1:0]       src_ready;
    logic                   fifo_full;
    logic                   fifo_wr;
    logic [8:0]             fifo_wdata;
    logic                   busy;
    logic [1:0]             grant_id;

    // Sources and FIFO status drive the scheduler
    modport master (
        output src_req, src_len, src_data, src_valid, fifo_full,
        input  src_ready, fifo_wr, fifo_wdata, busy, grant_id
    );

    // The scheduler itself
    modport slave (
        input  src_req, src_len, src_data, src_valid, fifo_full,
        output src_ready, fifo_wr, fifo_wdata, busy, grant_id
    );
endinterface

// File: rtl/spi_tx_scheduler_rr_arbiter.sv
// rtl/spi_tx_scheduler_rr_arbiter.sv - combinational round-robin pick of the first requester at or after ptr
module rr_arbiter
    import spi_tx_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] grant_idx,
    output logic            any_req
);

    // Scan offsets from far to near so the nearest requester above ptr wins
    always_comb begin
        int idx;
        idx       = 0;
        grant_idx = '0;
        any_req   = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                grant_idx = ID_W'(idx);
                any_req   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_tx_scheduler.sv
// rtl/spi_tx_scheduler.sv - round-robin burst framer into the shared SPI TX FIFO (checksum trailer under SPI_TX_SCHED_CHECKSUM_EN)
module spi_tx_scheduler
    import spi_tx_sched_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int LEN_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    spi_tx_scheduler_if.slave  bus
);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
`ifdef SPI_TX_SCHED_CHECKSUM_EN
    logic [7:0]        xor_q, xor_d;
`endif

    logic [ID_W-1:0]   arb_idx;
    logic              arb_any;
    logic [7:0]        g_data;
    logic              g_valid;
    logic              fifo_wr_c;
    logic [WORD_W-1:0] fifo_wdata_c;
    logic [N_SRC-1:0]  src_ready_c;
    logic              end_burst;

    rr_arbiter #(.N(N_SRC)) u_arb (
        .req       (bus.src_req),
        .ptr       (rr_ptr_q),
        .grant_idx (arb_idx),
        .any_req   (arb_any)
    );

    // Select the byte stream of the currently granted source
    always_comb begin
        g_data  = bus.src_data[int'(grant_id_q)*8 +: 8];
        g_valid = bus.src_valid[grant_id_q];
    end

    // Next-state logic plus Mealy write/ready so accept and write share a cycle
    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        rr_ptr_d     = rr_ptr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
`ifdef SPI_TX_SCHED_CHECKSUM_EN
        xor_d        = xor_q;
`endif
        fifo_wr_c    = 1'b0;
        fifo_wdata_c = '0;
        src_ready_c  = '0;
        end_burst    = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant_id_d = arb_idx;
                    len_d      = bus.src_len[int'(arb_idx)*LEN_W +: LEN_W];
                    state_d    = HEADER;
                end
            end
            HEADER: begin
                fifo_wdata_c = make_header(grant_id_q, HDR_LEN_W'(len_q));
                fifo_wr_c    = ~bus.fifo_full;
                if (!bus.fifo_full) begin
                    cnt_d = len_q;
`ifdef SPI_TX_SCHED_CHECKSUM_EN
                    xor_d = 8'h00;
`endif
                    // Zero-length bursts never enter PAYLOAD, so cnt cannot underflow
                    if (len_q == '0) end_burst = 1'b1;
                    else             state_d   = PAYLOAD;
                end
            end
            PAYLOAD: begin
                src_ready_c  = {{(N_SRC-1){1'b0}}, ~bus.fifo_full} << grant_id_q;
                fifo_wr_c    = g_valid & ~bus.fifo_full;
                fifo_wdata_c = {1'b0, g_data};
                if (fifo_wr_c) begin
                    cnt_d = cnt_q - 1'b1;
`ifdef SPI_TX_SCHED_CHECKSUM_EN
                    xor_d = xor_q ^ g_data;
`endif
                    if (cnt_q == LEN_W'(1)) end_burst = 1'b1;
                end
            end
`ifdef SPI_TX_SCHED_CHECKSUM_EN
            TRAILER: begin
                fifo_wdata_c = {1'b0, xor_q};
                fifo_wr_c    = ~bus.fifo_full;
                if (!bus.fifo_full) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase

        // Finished source drops to lowest priority for the next round
        if (end_burst) begin
            rr_ptr_d = (grant_id_q == ID_W'(N_SRC - 1)) ? '0 : grant_id_q + 1'b1;
`ifdef SPI_TX_SCHED_CHECKSUM_EN
            state_d  = TRAILER;
`else
            state_d  = IDLE;
`endif
        end

        busy_d = (state_d != IDLE);
    end

    // Register state, arbitration pointer, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
`ifdef SPI_TX_SCHED_CHECKSUM_EN
            xor_q      <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
`ifdef SPI_TX_SCHED_CHECKSUM_EN
            xor_q      <= xor_d;
`endif
        end
    end

    assign bus.fifo_wr    = fifo_wr_c;
    assign bus.fifo_wdata = fifo_wdata_c;
    assign bus.src_ready  = src_ready_c;
    assign bus.busy       = busy_q;
    assign bus.grant_id   = grant_id_q;

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// tb/tb_spi_tx_scheduler.sv - scoreboard bench for spi_tx_scheduler (checksum cases under SPI_TX_SCHED_CHECKSUM_EN)
module tb_spi_tx_scheduler;
    localparam int N  = 4;
    localparam int LW = 6;
`ifdef SPI_TX_SCHED_CHECKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic clk;
    logic reset;

    spi_tx_scheduler_if #(.N_SRC(N), .LEN_W(LW)) bus ();

    spi_tx_scheduler #(.N_SRC(N), .LEN_W(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [8:0]  exp_q[$];
    logic [7:0]  sq[4][$];
    logic [3:0]  req;
    logic [5:0]  lenv[4];
    logic [3:0]  rel;
    logic [1:0]  cur;
    int          rem, phase, pay_cnt;
    int          cyc, busy_cnt, wr_cnt, first_wr, last_wr;
    int          full_left, full_seen;
    bit          bp_arm, rst_arm, rst_now;
    logic        last_busy;

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.src_valid[i]          = (sq[i].size() > 0);
            bus.src_data[i*8 +: 8]    = (sq[i].size() > 0) ? sq[i][0] : 8'h00;
            bus.src_len[i*LW +: LW]   = lenv[i];
        end
        bus.src_req = req;
    endtask

    // One clock: monitor at negedge, then update source model after posedge
    task automatic step();
        logic [3:0] xfer;
        logic [8:0] w, e;
        rel = '0;
        @(negedge clk);
        xfer      = bus.src_valid & bus.src_ready;
        last_busy = bus.busy;
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.fifo_full === 1'b1) begin
            full_seen++;
            n_cmp++;
            if (bus.fifo_wr !== 1'b0 || bus.src_ready !== 4'b0000) begin
                n_bad++;
                $display("FAIL full_stall wr=%b ready=%b required wr=0 ready=0", bus.fifo_wr, bus.src_ready);
            end
        end
        if (bus.fifo_wr === 1'b1) begin
            w = bus.fifo_wdata;
            if (wr_cnt == 0) first_wr = cyc;
            last_wr = cyc;
            wr_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL fifo_word got=%h required=none", w);
            end else begin
                e = exp_q.pop_front();
                if (w !== e) begin
                    n_bad++;
                    $display("FAIL fifo_word got=%h required=%h", w, e);
                end
            end
            if (w[8]) begin
                cur = w[7:6]; rem = int'(w[5:0]); pay_cnt = 0;
                if (rem == 0) begin
                    if (CHK != 0) phase = 2;
                    else begin rel[cur] = 1'b1; phase = 0; end
                end else phase = 1;
            end else if (phase == 1) begin
                rem--; pay_cnt++;
                if (bp_arm && pay_cnt == 2) begin bp_arm = 0; full_left = 5; end
                if (rst_arm && pay_cnt == 2) begin rst_arm = 0; rst_now = 1; end
                if (rem == 0) begin
                    if (CHK != 0) phase = 2;
                    else begin rel[cur] = 1'b1; phase = 0; end
                end
            end else if (phase == 2) begin
                rel[cur] = 1'b1; phase = 0;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < N; i++) begin
            if (xfer[i] && sq[i].size() > 0) void'(sq[i].pop_front());
            if (rel[i]) req[i] = 1'b0;
        end
        if (full_left > 0) begin bus.fifo_full = 1'b1; full_left--; end
        else bus.fifo_full = 1'b0;
        if (rst_now) begin
            rst_now = 0; reset = 1'b1; req = '0;
            for (int i = 0; i < N; i++) sq[i].delete();
        end
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; exp_q.delete(); phase = 0;
        for (int i = 0; i < N; i++) begin sq[i].delete(); lenv[i] = '0; end
        bus.fifo_full = 1'b0; full_left = 0; bp_arm = 0; rst_arm = 0; rst_now = 0;
        drive();
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
    endtask

    // Raise a request and push the words this burst must produce
    task automatic start_src(input logic [1:0] id, input logic [5:0] len);
        logic [7:0] x;
        x = 8'h00;
        lenv[id] = len;
        req[id]  = 1'b1;
        exp_q.push_back({1'b1, id, len});
        for (int k = 0; k < sq[id].size(); k++) begin
            exp_q.push_back({1'b0, sq[id][k]});
            x = x ^ sq[id][k];
        end
        if (CHK != 0) exp_q.push_back({1'b0, x});
        drive();
    endtask

    task automatic run_until_idle(input int budget);
        int  n;
        bit  done;
        n = 0;
        done = 0;
        while (!done && n < budget) begin
            step();
            n++;
            done = (exp_q.size() == 0 && req == 4'b0000 && last_busy === 1'b0);
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL idle_timeout pending=%0d required=0 within %0d clks", exp_q.size(), budget);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++; if (bus.fifo_wr !== 1'b0) begin n_bad++; $display("FAIL rst_wr got=%b required=0", bus.fifo_wr); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b required=0", bus.busy); end
        n_cmp++; if (bus.grant_id !== 2'd0) begin n_bad++; $display("FAIL rst_grant got=%0d required=0", bus.grant_id); end
        n_cmp++; if (bus.src_ready !== 4'b0) begin n_bad++; $display("FAIL rst_ready got=%b required=0000", bus.src_ready); end
        n_cmp++; if (bus.fifo_wdata !== 9'h000) begin n_bad++; $display("FAIL rst_wdata got=%h required=000", bus.fifo_wdata); end
    endtask

    task automatic test_single();
        do_reset();
        sq[1].push_back(8'h11); sq[1].push_back(8'h22); sq[1].push_back(8'h33);
        busy_cnt = 0; wr_cnt = 0;
        start_src(2'd1, 6'd3);
        run_until_idle(60);
        n_cmp++; if (busy_cnt != 4 + CHK) begin n_bad++; $display("FAIL single_busy got=%0d required=%0d", busy_cnt, 4 + CHK); end
        n_cmp++; if (wr_cnt != 4 + CHK) begin n_bad++; $display("FAIL single_writes got=%0d required=%0d", wr_cnt, 4 + CHK); end
        n_cmp++; if (last_wr - first_wr != 3 + CHK) begin n_bad++; $display("FAIL single_span got=%0d required=%0d", last_wr - first_wr, 3 + CHK); end
        n_cmp++; if (bus.grant_id !== 2'd1) begin n_bad++; $display("FAIL single_grant got=%0d required=1", bus.grant_id); end
    endtask

    task automatic test_backpressure();
        // rr_ptr is 2 here; only src2 requests
        for (int k = 0; k < 6; k++) sq[2].push_back(8'($urandom_range(0, 255)));
        full_seen = 0; bp_arm = 1;
        start_src(2'd2, 6'd6);
        run_until_idle(80);
        n_cmp++; if (full_seen != 5) begin n_bad++; $display("FAIL bp_full_clks got=%0d required=5", full_seen); end
        n_cmp++; if (sq[2].size() != 0) begin n_bad++; $display("FAIL bp_left_bytes got=%0d required=0", sq[2].size()); end
    endtask

    task automatic test_round_robin();
        int n;
        do_reset();
        sq[0].push_back(8'hA0); sq[2].push_back(8'hA2); sq[3].push_back(8'hA3);
        start_src(2'd0, 6'd1);
        start_src(2'd2, 6'd1);
        start_src(2'd3, 6'd1);
        n = 0;
        while (req[0] === 1'b1 && n < 30) begin step(); n++; end
        n_cmp++; if (req[0] !== 1'b0) begin n_bad++; $display("FAIL rr_src0_done got=%b required=0", req[0]); end
        sq[0].push_back(8'h5A);
        start_src(2'd0, 6'd1);
        run_until_idle(80);
        n_cmp++; if (bus.grant_id !== 2'd0) begin n_bad++; $display("FAIL rr_last_grant got=%0d required=0", bus.grant_id); end
    endtask

    task automatic test_zero_len();
        do_reset();
        busy_cnt = 0; wr_cnt = 0;
        start_src(2'd3, 6'd0);
        run_until_idle(30);
        n_cmp++; if (wr_cnt != 1 + CHK) begin n_bad++; $display("FAIL zero_writes got=%0d required=%0d", wr_cnt, 1 + CHK); end
        n_cmp++; if (busy_cnt != 1 + CHK) begin n_bad++; $display("FAIL zero_busy got=%0d required=%0d", busy_cnt, 1 + CHK); end
        // rr_ptr wrapped to 0, so src0 beats src3
        sq[0].push_back(8'h77);
        start_src(2'd0, 6'd1);
        start_src(2'd3, 6'd0);
        run_until_idle(40);
        n_cmp++; if (bus.grant_id !== 2'd3) begin n_bad++; $display("FAIL zero_last_grant got=%0d required=3", bus.grant_id); end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        sq[1].push_back(8'h01);
        start_src(2'd1, 6'd1);
        run_until_idle(30);
        for (int k = 0; k < 5; k++) sq[1].push_back(8'hC0 + 8'(k));
        rst_arm = 1;
        start_src(2'd1, 6'd5);
        n = 0;
        while (reset !== 1'b1 && n < 60) begin step(); n++; end
        n_cmp++; if (reset !== 1'b1) begin n_bad++; $display("FAIL rstmid_reach got=%b required=1", reset); end
        @(posedge clk); #1;
        reset = 1'b0; exp_q.delete(); phase = 0;
        @(negedge clk);
        n_cmp++; if (bus.fifo_wr !== 1'b0) begin n_bad++; $display("FAIL rstmid_wr got=%b required=0", bus.fifo_wr); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got=%b required=0", bus.busy); end
        n_cmp++; if (bus.src_ready !== 4'b0) begin n_bad++; $display("FAIL rstmid_ready got=%b required=0000", bus.src_ready); end
        sq[0].push_back(8'h30); sq[3].push_back(8'h33);
        start_src(2'd0, 6'd1);
        start_src(2'd3, 6'd1);
        run_until_idle(40);
    endtask

`ifdef SPI_TX_SCHED_CHECKSUM_EN
    task automatic test_checksum();
        do_reset();
        sq[0].push_back(8'hA5); sq[0].push_back(8'h0F);
        lenv[0] = 6'd2; req[0] = 1'b1;
        exp_q.push_back(9'h102); exp_q.push_back(9'h0A5);
        exp_q.push_back(9'h00F); exp_q.push_back(9'h0AA);
        drive();
        run_until_idle(30);
    endtask
`endif

    initial begin
        cyc = 0; busy_cnt = 0; wr_cnt = 0; first_wr = 0; last_wr = 0;
        full_left = 0; full_seen = 0; phase = 0; rem = 0; pay_cnt = 0;
        cur = '0; rel = '0; last_busy = 1'b0; req = '0;
        bus.src_req = '0; bus.src_len = '0; bus.src_data = '0;
        bus.src_valid = '0; bus.fifo_full = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_round_robin();
        test_zero_len();
        test_reset_mid();
`ifdef SPI_TX_SCHED_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_tx_scheduler.md
Name: spi_tx_scheduler

Overview:
- Shares the single 9-bit SPI transmit FIFO between N_SRC packet sources, e.g. fingerprint peaks, spectrum debug and status.
- Arbitrates round-robin, frames each burst with a header word, then streams payload bytes into the FIFO under fifo_full back-pressure.
- Sits between the source blocks and the TX FIFO that feeds the SPI serializer.

Parameters:
N_SRC, 4, number of requesters (2..4; source ID field is 2 bits)
LEN_W, 6, payload length field width (bursts of 0..63 bytes)

Ports:
clk  in  1  system clock (FIFO write-side clock)
reset  in  1  reset, synchronous, active-high
src_req  in  N_SRC  source i has a burst pending; held until its burst completes
src_len  in  N_SRC*LEN_W  burst length per source; sampled at grant
src_data  in  N_SRC*8  payload byte per source
src_valid  in  N_SRC  src_data[i] is valid
src_ready  out  N_SRC  byte accepted this cycle (valid & ready = transfer)
fifo_full  in  1  TX FIFO cannot accept a word this cycle
fifo_wr  out  1  FIFO write strobe
fifo_wdata  out  9  word to FIFO
busy  out  1  a burst is in progress
grant_id  out  2  currently or last granted source

Behaviour:
- State machine (state_t): IDLE, HEADER, PAYLOAD, TRAILER (TRAILER only with the optional feature).
- Reset values: state=IDLE; rr_ptr=0; all outputs 0; grant_id=0.
- IDLE:
  - If any src_req is set, pick the first requester at or after rr_ptr, searching upward with wrap.
  - Register grant_id and len_q, which is src_len of the winner. Go to HEADER on the next clk.
  - busy=0 while in IDLE, 1 in every other state.
- HEADER:
  - fifo_wdata = {1'b1, grant_id, len_q}. With N_SRC<4, grant_id is zero-extended. fifo_wr = !fifo_full.
  - Advance only on an accepted write. If len_q==0, skip to the end-of-burst step.
  - No write is ever issued while fifo_full=1.
- PAYLOAD:
  - src_ready[g] = !fifo_full for the granted source g; all other ready bits are 0.
  - fifo_wr = src_valid[g] & !fifo_full. fifo_wdata = {1'b0, src_data[g]}.
  - fifo_wr, fifo_wdata and src_ready are combinational (Mealy) from the registered state, so accept and write happen in the same cycle.
  - Each transfer decrements the remaining count. On the transfer that takes the count to 0, run the end-of-burst step.
- End-of-burst step:
  - Set rr_ptr = grant_id+1, wrapping to 0 at N_SRC.
  - Go to IDLE, or to TRAILER when the feature is enabled.
- Throughput: one word per clk with no back-pressure.
  - Burst of L bytes = L+1 FIFO writes (L+2 with trailer), plus one IDLE arbitration cycle between bursts.
- Bit 8 marks the header. The downstream decoder resynchronises on bit 8 alone.
- Boundary cases:
  - src_valid low mid-burst: wait indefinitely, with no timeout.
  - src_req dropping mid-burst: ignored; the burst completes.
  - Simultaneous requests: resolved by rr_ptr. A source that just finished has lowest priority next round.
  - fifo_full asserted in the same cycle as src_valid: no transfer occurs and the byte is held by the source.
  - reset mid-burst: immediate return to IDLE and rr_ptr=0. The partial packet already in the FIFO is not retracted; the receiver drops it on the next header.
- All widths are unsigned. The length counter is LEN_W bits and never underflows, because the zero-length case skips PAYLOAD.

Optional Feature:
- Macro: SPI_TX_SCHED_CHECKSUM_EN.
- When defined:
  - An 8-bit XOR accumulator clears on the HEADER write and XORs every payload byte.
  - TRAILER writes {1'b0, xor_acc}, waiting on fifo_full, then returns to IDLE.
  - A zero-length burst still gets trailer 0x00.
  - The trailer is not counted in the header length.
- When undefined: no TRAILER state, no accumulator; the burst ends after its last payload byte.

Decomposition:
- Package spi_tx_sched_pkg holds:
  - state_t
  - HDR_MARKER (1'b1)
  - ID_W=2
  - header field positions ([8]=marker, [7:6]=id, [5:0]=len)
  - TRAILER state, included only under the macro
- One sub-module, rr_arbiter (parameter N), combinational:
  - Inputs: req, ptr.
  - Outputs: grant_idx, any_req.
- The FSM, counter and muxing stay in spi_tx_scheduler.

Test Plan:
- Single source: src1 requests with len=3, bytes 0x11/0x22/0x33, FIFO never full.
  -> FIFO receives 0x143, 0x011, 0x022, 0x033 on 4 consecutive clks; busy is high for exactly 4 clks.
- Round-robin: src0, src2 and src3 all request len=1, starting from reset.
  -> Header order is 0x101, 0x181, 0x1C1. src0 re-requesting after its burst is served after src3.
- Back-pressure: fifo_full high for 5 clks mid-payload.
  -> No fifo_wr and src_ready=0 during those clks; no byte lost or duplicated; order preserved.
- Zero length: src3 requests len=0.
  -> A single write of 0x1C0; return to IDLE; rr_ptr becomes 0.
- Reset mid-burst: assert reset after the 2nd payload byte of a len=5 burst.
  -> Next clk: fifo_wr=0, busy=0, src_ready=0; a following src0 request is granted first.
- With SPI_TX_SCHED_CHECKSUM_EN: len=2, bytes 0xA5 and 0x0F.
  -> Writes are 0x102, 0x0A5, 0x00F, 0x0AA.
